// File: rtl/axi_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_stream_rr_arbiter
//   Round-robin, non-preemptive arbiter that shares one downstream
//   valid/ready stream slave among NUM_REQ upstream stream masters.
//   A grant lasts at most BURST_LEN beats and ends early if the granted
//   master drops valid. One idle cycle always separates two grants.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_axi_data      NUM_REQ packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axi_valid     per-requester valid
//   s_axi_ready     per-requester ready (only the granted lane can be high)
//   m_axi_data      payload of the granted requester (0 while idle)
//   m_axi_valid     valid of the granted requester (0 while idle)
//   m_axi_ready     ready from the shared slave
//   m_axi_last      final beat of the current grant
//   grant_valid     a requester currently holds the grant
//   grant_id        granted requester index, 0 when no grant
// ---------------------------------------------------------------------------

// Per-requester datapath slice: gates the requester's ready and masks its
// payload so the top level can OR-reduce all lanes into m_axi_data.
module axi_stream_rr_arbiter_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  m_ready,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] data_q
);
  assign s_ready = sel & m_ready;
  assign data_q  = sel ? data : '0;
endmodule

module axi_stream_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axi_data,
  input  logic [NUM_REQ-1:0]            s_axi_valid,
  output logic [NUM_REQ-1:0]            s_axi_ready,
  output logic [DATA_WIDTH-1:0]         m_axi_data,
  output logic                          m_axi_valid,
  input  logic                          m_axi_ready,
  output logic                          m_axi_last,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  RST_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                                state;
  logic [CNT_W-1:0]                      beat_cnt;
  logic [ID_W-1:0]                       last_id;
  logic [ID_W-1:0]                       win_id;
  logic                                  win_vld;
  logic                                  cur_valid;
  logic                                  hs;
  logic                                  at_last;
  logic [NUM_REQ-1:0]                    sel;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    lane_data;

  // Round-robin search starting just after the last winner, so the
  // requester served most recently has the lowest priority.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_id) + i) % NUM_REQ);
      if (!win_vld && s_axi_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign cur_valid = s_axi_valid[grant_id];
  assign hs        = m_axi_valid & m_axi_ready;
  assign at_last   = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      last_id     <= RST_LAST;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_id    <= win_id;
            last_id     <= win_id;
            beat_cnt    <= '0;
          end
        end
        GRANT: begin
          // Valid low means nothing is pending (masters never retract a
          // presented beat), so releasing here loses no data.
          if (!cur_valid || (hs && at_last)) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            beat_cnt    <= '0;
          end else if (hs) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
          grant_id    <= '0;
          beat_cnt    <= '0;
        end
      endcase
    end
  end

  // One-hot lane select; all zero in IDLE, which forces idle outputs.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      sel[i] = (state == GRANT) && (grant_id == ID_W'(i));
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    axi_stream_rr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel     (sel[g]),
      .data    (s_axi_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .m_ready (m_axi_ready),
      .s_ready (s_axi_ready[g]),
      .data_q  (lane_data[g])
    );
  end

  always_comb begin
    m_axi_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      m_axi_data = m_axi_data | lane_data[i];
  end

  assign m_axi_valid = (state == GRANT) && cur_valid;
  assign m_axi_last  = m_axi_valid && at_last;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
module tb_axi_stream_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_axi_data;
  logic [3:0]   s_axi_valid;
  logic [3:0]   s_axi_ready;
  logic [31:0]  m_axi_data;
  logic         m_axi_valid, m_axi_ready, m_axi_last, grant_valid;
  logic [1:0]   grant_id;

  // second instance, BURST_LEN=1
  logic [127:0] b_data;
  logic [3:0]   b_valid, b_sready;
  logic [31:0]  b_mdata;
  logic         b_mvalid, b_mlast, b_gvalid;
  logic [1:0]   b_gid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q [4][$];
  logic [3:0]  hs;
  logic [36:0] obs;
  assign obs = {grant_valid, grant_id, m_axi_valid, m_axi_last, m_axi_data};

  always #5 clk = ~clk;

  axi_stream_rr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .s_axi_data(s_axi_data), .s_axi_valid(s_axi_valid), .s_axi_ready(s_axi_ready),
    .m_axi_data(m_axi_data), .m_axi_valid(m_axi_valid), .m_axi_ready(m_axi_ready),
    .m_axi_last(m_axi_last), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  axi_stream_rr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axi_data(b_data), .s_axi_valid(b_valid), .s_axi_ready(b_sready),
    .m_axi_data(b_mdata), .m_axi_valid(b_mvalid), .m_axi_ready(1'b1),
    .m_axi_last(b_mlast), .grant_valid(b_gvalid), .grant_id(b_gid)
  );

  // Upstream masters: each presents the head of its queue, holds it until
  // a handshake is seen, then advances.
  initial begin
    s_axi_valid = '0;
    s_axi_data  = '0;
  end
  always begin
    @(negedge clk);
    hs = s_axi_valid & s_axi_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
    for (int i = 0; i < 4; i++) begin
      s_axi_valid[i] = (q[i].size() > 0);
      s_axi_data[i*32 +: 32] = (q[i].size() > 0) ? q[i][0] : 32'h0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    m_axi_ready = 1'b1;
    b_valid = 4'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_axi_ready = 1'b1;
    q[2].push_back(32'h55);
    tick; tick; tick;
    n_tests++;
    if (obs !== 37'h0 || s_axi_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got obs=%h rdy=%b want obs=0 rdy=0", obs, s_axi_ready);
    end
    n_tests++;
    if ({b_gvalid, b_gid, b_mvalid, b_mlast, b_sready, b_mdata} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_b1 got gv=%b gid=%0d v=%b l=%b", b_gvalid, b_gid, b_mvalid, b_mlast);
    end
  endtask

  task automatic test_single;
    logic [36:0] exp;
    do_reset;
    for (int k = 0; k < 4; k++) q[2].push_back(32'hA0 + k);
    tick;
    n_tests++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c0_idle got gv=%b want 0", grant_valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick;
      exp = {1'b1, 2'd2, 1'b1, (c == 3), 32'hA0 + 32'(c)};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL single_beat%0d got %h want %h", c, obs, exp);
      end
    end
    tick;
    n_tests++;
    if (obs !== 37'h0) begin
      n_fail++;
      $display("FAIL single_release got %h want 0", obs);
    end
  endtask

  task automatic test_saturated;
    logic [36:0] exp;
    int g, pos, r, k, beats;
    do_reset;
    beats = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) q[i].push_back(32'h100 * i + j);
    tick;
    for (int c = 0; c < 25; c++) begin
      tick;
      g = c / 5; pos = c % 5; r = g % 4; k = (g / 4) * 4 + pos;
      if (pos < 4) exp = {1'b1, 2'(r), 1'b1, (pos == 3), 32'(32'h100 * r + k)};
      else         exp = 37'h0;
      if (m_axi_valid && m_axi_ready) beats++;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL saturated_c%0d got %h want %h", c, obs, exp);
      end
    end
    n_tests++;
    if (beats !== 20) begin
      n_fail++;
      $display("FAIL saturated_beats got %0d want 20", beats);
    end
  endtask

  task automatic test_early_release;
    logic [36:0] exp [5];
    do_reset;
    q[1].push_back(32'hC0); q[1].push_back(32'hC1);
    for (int k = 0; k < 4; k++) q[3].push_back(32'hD0 + k);
    exp[0] = {1'b1, 2'd1, 1'b1, 1'b0, 32'hC0};
    exp[1] = {1'b1, 2'd1, 1'b1, 1'b0, 32'hC1};
    exp[2] = {1'b1, 2'd1, 1'b0, 1'b0, 32'h0};
    exp[3] = 37'h0;
    exp[4] = {1'b1, 2'd3, 1'b1, 1'b0, 32'hD0};
    tick;
    for (int c = 0; c < 5; c++) begin
      tick;
      n_tests++;
      if (obs !== exp[c]) begin
        n_fail++;
        $display("FAIL early_release_c%0d got %h want %h", c, obs, exp[c]);
      end
    end
  endtask

  task automatic test_stall;
    logic        rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] dexp [6] = '{32'hE0, 32'hE1, 32'hE1, 32'hE1, 32'hE2, 32'hE3};
    logic        lexp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset;
    for (int k = 0; k < 4; k++) q[0].push_back(32'hE0 + k);
    q[1].push_back(32'hF0);
    tick;
    for (int c = 0; c < 6; c++) begin
      tick;
      m_axi_ready = rdy[c];
      #1;
      n_tests++;
      if ({m_axi_data, m_axi_last, s_axi_ready} !== {dexp[c], lexp[c], 3'b000, rdy[c]}) begin
        n_fail++;
        $display("FAIL stall_c%0d got d=%h l=%b rdy=%b want d=%h l=%b rdy=%b",
                 c, m_axi_data, m_axi_last, s_axi_ready, dexp[c], lexp[c], {3'b000, rdy[c]});
      end
    end
    m_axi_ready = 1'b1;
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    for (int k = 0; k < 4; k++) q[1].push_back(32'hB0 + k);
    tick;
    tick;
    n_tests++;
    if (obs !== {1'b1, 2'd1, 1'b1, 1'b0, 32'hB0}) begin
      n_fail++;
      $display("FAIL rstmid_beat0 got %h want grant 1 data B0", obs);
    end
    tick;
    rst = 1'b1;
    m_axi_ready = 1'b0;
    q[0].push_back(32'hC0);
    tick;
    n_tests++;
    if (grant_valid !== 1'b0 || s_axi_ready !== 4'b0 || m_axi_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle got gv=%b rdy=%b v=%b want 0", grant_valid, s_axi_ready, m_axi_valid);
    end
    rst = 1'b0;
    m_axi_ready = 1'b1;
    tick;
    n_tests++;
    if (obs !== {1'b1, 2'd0, 1'b1, 1'b0, 32'hC0}) begin
      n_fail++;
      $display("FAIL rstmid_priority got %h want grant 0 data C0", obs);
    end
  endtask

  task automatic test_burst1;
    logic [4:0] exp;
    do_reset;
    b_data  = {32'h3, 32'h2, 32'h1, 32'h0};
    b_valid = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (c % 2 == 0) exp = {1'b1, 2'((c / 2) % 2), 1'b1, 1'b1};
      else            exp = 5'b0;
      n_tests++;
      if ({b_gvalid, b_gid, b_mvalid, b_mlast} !== exp) begin
        n_fail++;
        $display("FAIL burst1_c%0d got gv=%b gid=%0d v=%b l=%b want %b",
                 c, b_gvalid, b_gid, b_mvalid, b_mlast, exp);
      end
    end
    n_tests++;
    if (b_mvalid && b_mdata !== 32'(b_gid)) begin
      n_fail++;
      $display("FAIL burst1_data got %h want %h", b_mdata, 32'(b_gid));
    end
    b_valid = 4'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_axi_ready = 1'b1;
    b_valid = 4'b0;
    b_data = '0;
    test_reset;
    test_single;
    test_saturated;
    test_early_release;
    test_stall;
    test_reset_mid_burst;
    test_burst1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
